key_filter: RTL and testbench

Multi-channel push-button input conditioner on the board's key pins: the input-side counterpart of the LED drivers. Each active-low mechanical key is synchronised to sys_clk and debounced by its own state machine. The block produces a clean pressed level per key plus single-cycle press, release and long-press event pulses. Downstream control logic (LED pattern select, speed control) consumes these pulses directly and never sees raw pins.

---
 rtl/key_filter.sv | 137 +++++++++++++
 tb/tb_key_filter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// Multi-channel push-button conditioner: two-flop synchroniser, per-key debounce FSM,
// registered pressed level plus one-cycle press / release / long-press pulses.
module key_filter #(
    parameter int KEY_NUM  = 4,
    parameter int DB_CYC   = 1_000_000,
    parameter int LONG_CYC = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_n,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int DB_W = $clog2(DB_CYC);
    localparam int LP_W = $clog2(LONG_CYC);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC - 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [KEY_NUM-1:0] sync_p0;
    logic [KEY_NUM-1:0] k_s;

    // Synchroniser stage: pins are inverted so 1 means pressed from here on
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            k_s     <= '0;
        end else begin
            sync_p0 <= ~key_n;
            k_s     <= sync_p0;
        end
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        state_t          state, state_nxt;
        logic [DB_W-1:0] db_cnt, db_cnt_nxt;
        logic [LP_W-1:0] lp_cnt, lp_cnt_nxt;
        logic            long_done, long_done_nxt;
        logic            level_q, level_nxt;
        logic            press_q, press_nxt;
        logic            release_q, release_nxt;
        logic            long_q, long_nxt;

        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                db_cnt    <= '0;
                lp_cnt    <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                db_cnt    <= db_cnt_nxt;
                lp_cnt    <= lp_cnt_nxt;
                long_done <= long_done_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
            end
        end

        always_comb begin
            state_nxt     = state;
            db_cnt_nxt    = db_cnt;
            lp_cnt_nxt    = lp_cnt;
            long_done_nxt = long_done;
            level_nxt     = level_q;
            press_nxt     = 1'b0;
            release_nxt   = 1'b0;
            long_nxt      = 1'b0;

            // Hold timer runs through release bounce so a glitch never restarts it
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (lp_cnt != LP_MAX) begin
                    lp_cnt_nxt = lp_cnt + LP_W'(1);
                end else if (!long_done) begin
                    long_nxt      = 1'b1;
                    long_done_nxt = 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (k_s[i]) begin
                        state_nxt  = PRESS_WAIT;
                        db_cnt_nxt = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!k_s[i]) begin
                        state_nxt = IDLE;
                    end else if (db_cnt == DB_MAX) begin
                        state_nxt     = PRESSED;
                        level_nxt     = 1'b1;
                        press_nxt     = 1'b1;
                        lp_cnt_nxt    = '0;
                        long_done_nxt = 1'b0;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!k_s[i]) begin
                        state_nxt  = RELEASE_WAIT;
                        db_cnt_nxt = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (k_s[i]) begin
                        state_nxt = PRESSED;
                    end else if (db_cnt == DB_MAX) begin
                        state_nxt   = IDLE;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign key_state[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule

// File: tb/tb_key_filter.sv
// Scoreboard bench for key_filter: expected pulse events are queued when keys are driven
// and matched, with their edge number, whenever the DUT emits any pulse.
module tb_key_filter;

    localparam int KEY_NUM  = 4;
    localparam int DB_CYC   = 8;
    localparam int LONG_CYC = 32;
    localparam int LAT      = DB_CYC + 3;

    logic               sys_clk = 1'b0;
    logic               rst_n;
    logic [KEY_NUM-1:0] key_n;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } evt_t;
    evt_t sb[$];

    key_filter #(
        .KEY_NUM (KEY_NUM),
        .DB_CYC  (DB_CYC),
        .LONG_CYC(LONG_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int c, input logic [3:0] p, input logic [3:0] r,
                              input logic [3:0] l);
        evt_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    always @(negedge sys_clk) begin
        evt_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_evt", 32'(cyc), 32'(e.cyc));
        end
        if ((key_press | key_release | key_long) != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {20'd0, key_press, key_release, key_long}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("evt_edge", 32'(cyc), 32'(e.cyc));
                check("evt_press", 32'(key_press), 32'(e.press));
                check("evt_release", 32'(key_release), 32'(e.rel));
                check("evt_long", 32'(key_long), 32'(e.lng));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int p;
        int r;
        rst_n = 1'b0;
        key_n = '1;
        @(negedge sys_clk);
        check("reset_state", 32'(key_state), 32'd0);
        check("reset_pulses", {20'd0, key_press, key_release, key_long}, 32'd0);
        wait_to(3);
        rst_n = 1'b1;

        // Clean press and release on key 0
        wait_to(5);
        c = cyc;
        key_n[0] = 1'b0;
        expect_evt(c + LAT, 4'b0001, 4'b0000, 4'b0000);
        wait_to(c + LAT - 1);
        check("clean_state_before", 32'(key_state), 32'd0);
        wait_to(c + LAT);
        check("clean_state", 32'(key_state), 32'b0001);
        wait_to(c + 15);
        key_n[0] = 1'b1;
        expect_evt(c + 15 + LAT, 4'b0000, 4'b0001, 4'b0000);
        wait_to(c + 15 + LAT);
        check("clean_rel_state", 32'(key_state), 32'd0);

        // Bouncing key 1: 3-cycle segments for 30 cycles, then held low
        wait_to(cyc + 3);
        c = cyc;
        for (int s = 0; s < 10; s++) begin
            wait_to(c + 3 * s);
            key_n[1] = s[0];
        end
        wait_to(c + 29);
        check("bounce_state", 32'(key_state), 32'd0);
        wait_to(c + 30);
        key_n[1] = 1'b0;
        expect_evt(c + 30 + LAT, 4'b0010, 4'b0000, 4'b0000);
        wait_to(c + 30 + LAT);
        check("bounce_press_state", 32'(key_state), 32'b0010);
        wait_to(c + 45);
        key_n[1] = 1'b1;
        expect_evt(c + 45 + LAT, 4'b0000, 4'b0010, 4'b0000);
        wait_to(c + 46 + LAT);

        // Key 2: release glitch rejected, then release confirmed on the long-press edge
        c = cyc;
        key_n[2] = 1'b0;
        p = c + LAT;
        expect_evt(p, 4'b0100, 4'b0000, 4'b0000);
        wait_to(p + 2);
        key_n[2] = 1'b1;
        wait_to(p + 7);
        key_n[2] = 1'b0;
        wait_to(p + 20);
        check("glitch_state", 32'(key_state), 32'b0100);
        wait_to(p + 21);
        key_n[2] = 1'b1;
        expect_evt(p + LONG_CYC, 4'b0000, 4'b0100, 4'b0100);
        wait_to(p + LONG_CYC + 1);
        check("glitch_rel_state", 32'(key_state), 32'd0);

        // Key 3: long hold gives exactly one long pulse
        wait_to(cyc + 2);
        c = cyc;
        key_n[3] = 1'b0;
        p = c + LAT;
        expect_evt(p, 4'b1000, 4'b0000, 4'b0000);
        expect_evt(p + LONG_CYC, 4'b0000, 4'b0000, 4'b1000);
        wait_to(p + 100);
        check("long_hold_state", 32'(key_state), 32'b1000);
        key_n[3] = 1'b1;
        expect_evt(p + 100 + LAT, 4'b0000, 4'b1000, 4'b0000);
        wait_to(p + 101 + LAT);
        check("long_rel_state", 32'(key_state), 32'd0);

        // All keys at once
        c = cyc;
        key_n = 4'b0000;
        expect_evt(c + LAT, 4'b1111, 4'b0000, 4'b0000);
        wait_to(c + LAT);
        check("simul_state", 32'(key_state), 32'b1111);
        wait_to(c + 20);
        key_n = 4'b1111;
        expect_evt(c + 20 + LAT, 4'b0000, 4'b1111, 4'b0000);
        wait_to(c + 21 + LAT);
        check("simul_rel_state", 32'(key_state), 32'd0);

        // Reset while key 0 is held
        c = cyc;
        key_n[0] = 1'b0;
        p = c + LAT;
        expect_evt(p, 4'b0001, 4'b0000, 4'b0000);
        wait_to(p + 4);
        check("pre_reset_state", 32'(key_state), 32'b0001);
        rst_n = 1'b0;
        #1;
        check("mid_reset_state", 32'(key_state), 32'd0);
        check("mid_reset_pulses", {20'd0, key_press, key_release, key_long}, 32'd0);
        wait_to(p + 7);
        rst_n = 1'b1;
        r = cyc;
        expect_evt(r + LAT, 4'b0001, 4'b0000, 4'b0000);
        wait_to(r + LAT);
        check("post_reset_state", 32'(key_state), 32'b0001);
        wait_to(r + 15);
        key_n[0] = 1'b1;
        expect_evt(r + 15 + LAT, 4'b0000, 4'b0001, 4'b0000);
        wait_to(r + 20 + LAT);
        check("final_state", 32'(key_state), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
